// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Lets N requesters take turns on one sequential shift-add multiplier.
//   A round-robin arbiter accepts one job at a time. The controller then
//   resets, arms and starts the multiplier, and waits for finish. The product
//   goes back to the requester that issued the job. A watchdog returns an
//   error response if finish never arrives.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester job handshake (ready is one-hot or zero)
//   req_a/req_b         packed operands, requester i at [i*LEN +: LEN]
//   resp_valid/ready    per-requester response handshake (valid is one-hot)
//   resp_product        shared response data, resp_err flags a timeout
//   busy, grant_id      controller not idle / index of the job in flight
//   mul_*               multiplier control, operands and result
module mul_share_arbiter #(
  parameter  int LEN     = 32,
  parameter  int N       = 4,
  parameter  int TIMEOUT = 2 * LEN,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*LEN-1:0]     req_a,
  input  logic [N*LEN-1:0]     req_b,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ready,
  output logic [2*LEN-1:0]     resp_product,
  output logic                 resp_err,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 mul_rst,
  output logic                 mul_start,
  output logic [LEN-1:0]       mul_multiplicand,
  output logic [LEN-1:0]       mul_multiplier,
  input  logic [2*LEN-1:0]     mul_product,
  input  logic                 mul_finish
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_LAUNCH, S_WAIT, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [LEN-1:0]     opa_q, opa_d;
  logic [LEN-1:0]     opb_q, opb_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic [2*LEN-1:0]   resp_product_q, resp_product_d;
  logic               resp_err_q, resp_err_d;
  logic               mul_rst_q, mul_rst_d;
  logic               mul_start_q, mul_start_d;

  logic [LEN-1:0]     a_arr [N];
  logic [LEN-1:0]     b_arr [N];
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic               accept;

  // Unpack the flat operand buses into per-requester lanes.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*LEN +: LEN];
      assign b_arr[gi] = req_b[gi*LEN +: LEN];
    end
  endgenerate

  // Round-robin pick: scan starting one past the last winner.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // rst_n gates the grant so that req_ready reads zero while reset is held.
  assign accept = (state_q == S_IDLE) && win_found && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= IDW'(N - 1);
      grant_id_q     <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      wdog_q         <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      mul_rst_q      <= 1'b1;
      mul_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      wdog_q         <= wdog_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      mul_rst_q      <= mul_rst_d;
      mul_start_q    <= mul_start_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    wdog_d         = wdog_q;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d      = a_arr[win_idx];
          opb_d      = b_arr[win_idx];
          grant_id_d = win_idx;
          rr_ptr_d   = win_idx;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR:  state_d = S_ARM;
      S_ARM:    state_d = S_LAUNCH;
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        // finish wins over the watchdog when both land on the same cycle;
        // finish is only trusted here since it survives a multiplier reset.
        if (mul_finish) begin
          resp_product_d = mul_product;
          resp_err_d     = 1'b0;
          state_d        = S_RESP;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          resp_product_d = '0;
          resp_err_d     = 1'b1;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready[grant_id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. mul_rst/mul_start are registered from the next state so they
  // line up exactly with CLEAR/LAUNCH and mul_rst reads high during reset.
  always_comb begin
    req_ready   = '0;
    resp_valid  = '0;
    mul_rst_d   = (state_d == S_CLEAR);
    mul_start_d = (state_d == S_LAUNCH);
    if (accept) req_ready[win_idx] = 1'b1;
    if (state_q == S_RESP) resp_valid[grant_id_q] = 1'b1;
  end

  assign busy             = (state_q != S_IDLE);
  assign grant_id         = grant_id_q;
  assign resp_product     = resp_product_q;
  assign resp_err         = resp_err_q;
  assign mul_rst          = mul_rst_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter: a behavioural shift-add multiplier model plus
// a round-robin / product / latency reference model, driven by directed and
// randomized jobs.
module tb_mul_share_arbiter;
  localparam int LEN = 32;
  localparam int N = 4;
  localparam int TIMEOUT = 2 * LEN;
  localparam int IDW = $clog2(N);

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*LEN-1:0]   req_a;
  logic [N*LEN-1:0]   req_b;
  logic [N-1:0]       resp_valid;
  logic [N-1:0]       resp_ready;
  logic [2*LEN-1:0]   resp_product;
  logic               resp_err;
  logic               busy;
  logic [IDW-1:0]     grant_id;
  logic               mul_rst;
  logic               mul_start;
  logic [LEN-1:0]     mul_multiplicand;
  logic [LEN-1:0]     mul_multiplier;
  logic [2*LEN-1:0]   mul_product;
  logic               mul_finish;

  mul_share_arbiter #(.LEN(LEN), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_err(resp_err),
    .busy(busy), .grant_id(grant_id),
    .mul_rst(mul_rst), .mul_start(mul_start),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_finish(mul_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: one job per reset, finish LEN cycles after start,
  // finish survives reset (cleared only when a new job starts).
  bit               hang = 1'b0;
  logic             m_run = 1'b0;
  int               m_cnt = 0;
  logic             m_fin = 1'b0;
  logic [2*LEN-1:0] m_prod = '0;
  logic [LEN-1:0]   m_a = '0;
  logic [LEN-1:0]   m_b = '0;

  always @(posedge clk) begin
    if (mul_rst) begin
      m_run <= 1'b0;
      m_cnt <= 0;
      m_a   <= mul_multiplicand;
      m_b   <= mul_multiplier;
    end else if (!m_run) begin
      m_a <= mul_multiplicand;
      m_b <= mul_multiplier;
      if (mul_start) begin
        m_run <= 1'b1;
        m_cnt <= 0;
        m_fin <= 1'b0;
      end
    end else if (m_cnt == LEN - 1) begin
      m_run <= 1'b0;
      if (!hang) begin
        m_fin  <= 1'b1;
        m_prod <= (2*LEN)'(m_a) * (2*LEN)'(m_b);
      end
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign mul_finish  = m_fin;
  assign mul_product = m_prod;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = N - 1;
  int job_no  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 1; k <= N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    req_a[i*LEN +: LEN] = a;
    req_b[i*LEN +: LEN] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rr_m = N - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  // One full job: grant, sequencing latency, response, backpressure, release.
  task automatic run_job(input logic [N-1:0] mask, input bit keep, input int hold, input bit exp_to);
    int w, lat, starts, bad_rdy, bad_hold;
    logic [N-1:0] one;
    logic [LEN-1:0] a, b;
    logic [63:0] ep;
    req_valid = mask;
    #1;
    w = rr_pick(mask, rr_m);
    one = '0;
    one[w] = 1'b1;
    a = req_a[w*LEN +: LEN];
    b = req_b[w*LEN +: LEN];
    ep = exp_to ? 64'd0 : (64'(a) * 64'(b));
    check_eq("req_ready", 64'(req_ready), 64'(one));
    tick();
    rr_m = w;
    if (!keep) req_valid = '0;
    check_eq("grant_id", 64'(grant_id), 64'(w));
    check_eq("busy_after_accept", 64'(busy), 64'd1);
    check_eq("mul_rst_clear", 64'(mul_rst), 64'd1);
    check_eq("operands", {mul_multiplicand, mul_multiplier}, {a, b});
    lat = 0; starts = 0; bad_rdy = 0;
    while (resp_valid == '0 && lat < 200) begin
      if (mul_start) starts++;
      if (req_ready != '0) bad_rdy++;
      tick();
      lat++;
    end
    check_eq("latency", 64'(lat), exp_to ? 64'(TIMEOUT + 3) : 64'(LEN + 4));
    check_eq("mul_start_pulses", 64'(starts), 64'd1);
    check_eq("ready_while_busy", 64'(bad_rdy), 64'd0);
    check_eq("resp_valid", 64'(resp_valid), 64'(one));
    check_eq("resp_product", resp_product, ep);
    check_eq("resp_err", 64'(resp_err), 64'(exp_to));
    resp_ready = ~one;
    bad_hold = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (resp_valid !== one || resp_product !== ep || req_ready != '0) bad_hold++;
    end
    if (hold > 0) check_eq("hold_stable", 64'(bad_hold), 64'd0);
    resp_ready = one | N'($urandom);
    tick();
    resp_ready = '0;
    check_eq("resp_valid_drop", 64'(resp_valid), 64'd0);
    check_eq("idle_after_resp", 64'(busy), 64'd0);
    $display("[TB] job %0d: req=%0d a=0x%0h b=0x%0h product=0x%0h err=%0d latency=%0d hold=%0d",
             job_no, w, a, b, resp_product, resp_err, lat, hold);
    job_no++;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [N-1:0] m;
    rst_n = 1'b0;
    req_valid = '1;
    resp_ready = '0;
    req_a = '0;
    req_b = '0;
    #1;
    repeat (2) tick();
    // Reset state, with requests pending to show ready is held off.
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mul_rst", 64'(mul_rst), 64'd1);
    check_eq("rst_mul_start", 64'(mul_start), 64'd0);
    check_eq("rst_outputs", {resp_product, 31'd0, resp_err, 30'(grant_id), mul_multiplicand, mul_multiplier},
             {64'd0, 64'd0, 64'd0});
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    check_eq("mul_rst_held", 64'(mul_rst), 64'd1);
    tick();
    check_eq("mul_rst_release", 64'(mul_rst), 64'd0);

    // Single job.
    set_ops(1, 32'd7, 32'd6);
    run_job(4'b0010, 1'b0, 0, 1'b0);

    // Round robin from reset, all requesters pending.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, LEN'(i + 1), 32'd3);
    for (int j = 0; j < 5; j++) run_job(4'b1111, 1'b1, 0, 1'b0);
    req_valid = '0;

    // Response backpressure on an all-ones product.
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_job(4'b0100, 1'b0, 10, 1'b0);
    check_eq("max_product", resp_product, 64'hFFFF_FFFE_0000_0001);

    // Timeout, then recovery.
    hang = 1'b1;
    set_ops(3, LEN'($urandom), LEN'($urandom));
    run_job(4'b1000, 1'b0, 0, 1'b1);
    hang = 1'b0;
    set_ops(3, 32'd3, 32'd5);
    run_job(4'b1000, 1'b0, 0, 1'b0);

    // Reset 10 cycles into WAIT discards the job.
    set_ops(0, LEN'($urandom), LEN'($urandom));
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    repeat (13) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_mul_rst", 64'(mul_rst), 64'd1);
    check_eq("midrst_outputs", {resp_product, 30'(grant_id), 31'(resp_valid), resp_err, mul_start},
             64'd0 << 64);
    rr_m = N - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (resp_valid != '0) cnt++;
    end
    check_eq("no_resp_after_reset", 64'(cnt), 64'd0);
    set_ops(0, 32'd2, 32'd2);
    run_job(4'b0001, 1'b0, 0, 1'b0);

    // Randomized jobs; finish is left high from the previous job, so each
    // one also exercises the stale-finish case.
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: set_ops(i, '0, LEN'($urandom));
          1: set_ops(i, '1, LEN'($urandom));
          default: set_ops(i, LEN'($urandom), LEN'($urandom));
        endcase
      end
      m = N'($urandom);
      if (m == '0) m = 4'b0001;
      run_job(m, 1'($urandom), int'($urandom_range(0, 5)), 1'b0);
    end
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
